// File: rtl/ttl_74259_sync_if.sv
`default_nettype none
// ============================================================================
// Module     : ttl_74259_sync_if
// Description: Signal bundle for the synchronous 74LS259 addressable latch.
//              Carries the per-block controls and data, the shared cell
//              address and the packed latch outputs.
//                Clear_bar  [BLOCKS]            per-block clear, active-low
//                Enable_bar [BLOCKS]            per-block write enable, active-low
//                Select     [WIDTH_SELECT]      cell address shared by all blocks
//                D          [BLOCKS]            per-block data bit
//                Q_2D       [BLOCKS*WIDTH_OUT]  packed outputs, block b at
//                                               [b*WIDTH_OUT +: WIDTH_OUT]
//              master: the writer (drives controls, reads Q_2D)
//              slave : the latch bank (reads controls, drives Q_2D)
// Revision   : 1.0  initial release
// ============================================================================
interface ttl_74259_sync_if #(
  parameter int BLOCKS       = 1,
  parameter int WIDTH_OUT    = 8,
  parameter int WIDTH_SELECT = $clog2(WIDTH_OUT)
) ();

  logic [BLOCKS-1:0]           Clear_bar;
  logic [BLOCKS-1:0]           Enable_bar;
  logic [WIDTH_SELECT-1:0]     Select;
  logic [BLOCKS-1:0]           D;
  logic [BLOCKS*WIDTH_OUT-1:0] Q_2D;

  modport master (
    output Clear_bar,
    output Enable_bar,
    output Select,
    output D,
    input  Q_2D
  );

  modport slave (
    input  Clear_bar,
    input  Enable_bar,
    input  Select,
    input  D,
    output Q_2D
  );

endinterface : ttl_74259_sync_if
`default_nettype wire

// File: rtl/ttl_74259_sync.sv
`default_nettype none
// ============================================================================
// Module     : ttl_74259_sync
// Description: Clocked 74LS259 8-bit addressable latch. Each of BLOCKS
//              independent blocks steers its data bit into the cell chosen by
//              the shared Select bus. All state changes on the rising edge of
//              Clk; there is no combinational path from inputs to Q_2D.
//              Ports:
//                Clk    in  core clock
//                Reset  in  synchronous reset, active-high, clears every cell
//                bus    ttl_74259_sync_if.slave (Clear_bar, Enable_bar,
//                       Select, D in; Q_2D out)
//              Per-block mode (Clear_bar, Enable_bar) at each edge:
//                1,0 ADDRESS : cell[Select] <= D, other cells hold
//                1,1 MEMORY  : all cells hold
//                0,0 DEMUX   : cell[Select] <= D, other cells <= 0
//                0,1 CLEAR   : all cells <= 0
// Revision   : 1.0  initial release
// ============================================================================
module ttl_74259_sync #(
  parameter int BLOCKS       = 1,
  parameter int WIDTH_OUT    = 8,
  parameter int WIDTH_SELECT = $clog2(WIDTH_OUT),
  // Output delays of the original TTL part. The register bank drives Q_2D
  // directly; these are kept so existing instantiations still elaborate.
  parameter int DELAY_RISE   = 12,
  parameter int DELAY_FALL   = 15
) (
  input  wire logic           Clk,
  input  wire logic           Reset,
  ttl_74259_sync_if.slave     bus
);

  localparam int C_CELLS = BLOCKS * WIDTH_OUT;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if ((WIDTH_OUT < 2) || (WIDTH_OUT != (1 << WIDTH_SELECT))) begin : g_bad_width
    $error("ttl_74259_sync: WIDTH_OUT must be a power of two >= 2 equal to 2**WIDTH_SELECT");
  end

  if (BLOCKS < 1) begin : g_bad_blocks
    $error("ttl_74259_sync: BLOCKS must be at least 1");
  end

  if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
    $error("ttl_74259_sync: DELAY_RISE/DELAY_FALL must be non-negative");
  end

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  logic [C_CELLS-1:0] q_q;
  logic [C_CELLS-1:0] q_d;

  // Per-block control decode, named for readability of the next-state logic.
  logic [BLOCKS-1:0] w_write;   // Enable_bar low: addressed cell takes D
  logic [BLOCKS-1:0] w_wipe;    // Clear_bar low: unaddressed cells go to 0

  assign w_write = ~bus.Enable_bar;
  assign w_wipe  = ~bus.Clear_bar;

  // Next-state computation. The address match drives a ternary rather than
  // an if so that an unknown Select during a write resolves to X on the
  // cells of the writing block in four-state simulation, instead of being
  // silently treated as "no match". Blocks not writing never look at Select.
  always_comb begin
    q_d = q_q;
    for (int b = 0; b < BLOCKS; b++) begin
      for (int i = 0; i < WIDTH_OUT; i++) begin
        logic hit;
        logic keep_or_clear;
        hit           = (bus.Select == WIDTH_SELECT'(i));
        keep_or_clear = w_wipe[b] ? 1'b0 : q_q[b*WIDTH_OUT + i];
        if (w_write[b]) begin
          q_d[b*WIDTH_OUT + i] = hit ? bus.D[b] : keep_or_clear;
        end else begin
          q_d[b*WIDTH_OUT + i] = keep_or_clear;
        end
      end
    end
  end

  // Reset overrides every mode of every block and discards any write
  // sampled on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q_2D = q_q;

endmodule : ttl_74259_sync
`default_nettype wire

// File: tb/tb_ttl_74259_sync.sv
`default_nettype none
// ============================================================================
// Module     : tb_ttl_74259_sync
// Description: Directed self-checking bench for ttl_74259_sync. Instance
//              u_dut_a is the single 8-cell block; u_dut_b has two blocks for
//              the independent-block checks. Expected values are hand-derived.
// Revision   : 1.0  initial release
// ============================================================================
module tb_ttl_74259_sync;

  logic Clk;
  logic Reset;

  int n_vec;
  int n_err;

  ttl_74259_sync_if #(.BLOCKS(1), .WIDTH_OUT(8), .WIDTH_SELECT(3)) a_if ();
  ttl_74259_sync_if #(.BLOCKS(2), .WIDTH_OUT(8), .WIDTH_SELECT(3)) b_if ();

  ttl_74259_sync #(
    .BLOCKS(1), .WIDTH_OUT(8), .WIDTH_SELECT(3), .DELAY_RISE(12), .DELAY_FALL(15)
  ) u_dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (a_if.slave)
  );

  ttl_74259_sync #(
    .BLOCKS(2), .WIDTH_OUT(8), .WIDTH_SELECT(3), .DELAY_RISE(12), .DELAY_FALL(15)
  ) u_dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1 ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Single-block controls on instance A.
  task automatic set_a(input logic clr_n, input logic en_n, input logic [2:0] sel, input logic d);
    a_if.Clear_bar  = clr_n;
    a_if.Enable_bar = en_n;
    a_if.Select     = sel;
    a_if.D          = d;
  endtask

  task automatic set_b(input logic [1:0] clr_n, input logic [1:0] en_n,
                       input logic [2:0] sel, input logic [1:0] d);
    b_if.Clear_bar  = clr_n;
    b_if.Enable_bar = en_n;
    b_if.Select     = sel;
    b_if.D          = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    // Arbitrary activity during reset: DEMUX writes of 1.
    set_a(1'b0, 1'b0, 3'd4, 1'b1);
    set_b(2'b00, 2'b00, 3'd4, 2'b11);
    #2;

    // ---- 1: reset ----
    step();
    chk("reset_a", {8'h00, a_if.Q_2D}, 16'h0000);
    chk("reset_b", b_if.Q_2D, 16'h0000);
    set_a(1'b1, 1'b0, 3'd5, 1'b1);
    set_b(2'b11, 2'b00, 3'd5, 2'b11);
    step();
    chk("reset_hold_a", {8'h00, a_if.Q_2D}, 16'h0000);
    step();
    chk("reset_hold_b", b_if.Q_2D, 16'h0000);

    Reset = 1'b0;
    set_b(2'b11, 2'b11, 3'd0, 2'b00);   // B in MEMORY while A is exercised

    // ---- 2: ADDRESS ----
    set_a(1'b1, 1'b0, 3'd3, 1'b1);
    step();
    chk("addr_sel3", {8'h00, a_if.Q_2D}, 16'h0008);
    set_a(1'b1, 1'b0, 3'd6, 1'b1);
    #1;
    chk("addr_no_comb_path", {8'h00, a_if.Q_2D}, 16'h0008);
    step();
    chk("addr_sel6", {8'h00, a_if.Q_2D}, 16'h0048);
    set_a(1'b1, 1'b0, 3'd3, 1'b0);
    step();
    chk("addr_sel3_clr", {8'h00, a_if.Q_2D}, 16'h0040);

    // ---- 3: MEMORY then CLEAR ----
    set_a(1'b1, 1'b0, 3'd1, 1'b1); step();   // 0x42
    set_a(1'b1, 1'b0, 3'd3, 1'b1); step();   // 0x4A
    set_a(1'b1, 1'b0, 3'd4, 1'b1); step();   // 0x5A
    chk("mem_setup", {8'h00, a_if.Q_2D}, 16'h005A);
    for (int k = 0; k < 10; k++) begin
      set_a(1'b1, 1'b1, 3'(k), k[0]);
      step();
      chk("mem_hold", {8'h00, a_if.Q_2D}, 16'h005A);
    end
    set_a(1'b0, 1'b1, 3'd2, 1'b1);
    step();
    chk("clear", {8'h00, a_if.Q_2D}, 16'h0000);

    // ---- 4: DEMUX ----
    for (int k = 0; k < 8; k++) begin
      set_a(1'b1, 1'b0, 3'(k), 1'b1);
      step();
    end
    chk("demux_setup", {8'h00, a_if.Q_2D}, 16'h00FF);
    set_a(1'b0, 1'b0, 3'd2, 1'b1);
    step();
    chk("demux_d1", {8'h00, a_if.Q_2D}, 16'h0004);
    set_a(1'b0, 1'b0, 3'd2, 1'b0);
    step();
    chk("demux_d0", {8'h00, a_if.Q_2D}, 16'h0000);

    // ---- 5: two independent blocks ----
    set_a(1'b1, 1'b1, 3'd0, 1'b0);          // A in MEMORY
    for (int k = 0; k < 8; k++) begin
      set_b(2'b11, 2'b01, 3'(k), 2'b10);    // blk1 ADDRESS D=1, blk0 MEMORY
      step();
    end
    chk("blk_setup", b_if.Q_2D, 16'hFF00);
    set_b(2'b01, 2'b10, 3'd7, 2'b01);       // blk0 ADDRESS D=1, blk1 CLEAR
    step();
    chk("blk_mixed", b_if.Q_2D, 16'h0080);
    set_b(2'b10, 2'b00, 3'd5, 2'b11);       // blk0 DEMUX, blk1 ADDRESS, both D=1
    step();
    chk("blk_demux_addr", b_if.Q_2D, 16'h2020);
    chk("blk_a_untouched", {8'h00, a_if.Q_2D}, 16'h0000);

    // ---- 6: reset collides with a write ----
    set_b(2'b11, 2'b11, 3'd0, 2'b00);
    set_a(1'b1, 1'b0, 3'd0, 1'b1);
    step();
    chk("pre_reset", {8'h00, a_if.Q_2D}, 16'h0001);
    Reset = 1'b1;
    set_a(1'b1, 1'b0, 3'd1, 1'b1);
    step();
    chk("reset_wins", {8'h00, a_if.Q_2D}, 16'h0000);
    chk("reset_wins_b", b_if.Q_2D, 16'h0000);
    Reset = 1'b0;
    step();
    chk("post_reset_write", {8'h00, a_if.Q_2D}, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule : tb_ttl_74259_sync
`default_nettype wire
